// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, error codes and loader state encoding for the priority arbiter slice
package arb_pkg;
  localparam int ARB_NUM_PERIPH = 16;
  localparam int ARB_IDX_W = 4;
  localparam int ARB_PRIO_W = 4;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_REQ,
    S_RD_CHK,
    S_FINISH,
    S_FAIL
  } load_state_e;
endpackage

// File: rtl/handshake_timeout_cnt.sv
// handshake_timeout_cnt: counts stalled handshake cycles and pulses expired on the TIMEOUT-th one
module handshake_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expired = en && !clear && cnt == CW'(TIMEOUT - 1);
  // wait counter, restarted whenever the handshake completes or no request is pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/priority_table_loader.sv
// priority_table_loader: writes a captured priority table into the arbiter memory and optionally reads it back
module priority_table_loader
  import arb_pkg::*;
#(
  parameter int NUM_PERIPH = ARB_NUM_PERIPH,
  parameter int IDX_W = ARB_IDX_W,
  parameter int PRIO_W = ARB_PRIO_W,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         verify_en,
  input  logic                         abort,
  input  logic [NUM_PERIPH*PRIO_W-1:0] prio_table,
  output logic                         valid,
  output logic                         wr_rd,
  output logic [IDX_W-1:0]             peripheral_index,
  output logic [PRIO_W-1:0]            wr_priorities,
  input  logic                         ready,
  input  logic [PRIO_W-1:0]            rd_priorities,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   err_code,
  output logic [IDX_W-1:0]             err_index
);
  load_state_e state, state_d;
  logic [IDX_W-1:0] idx, idx_d, err_index_d;
  logic [NUM_PERIPH*PRIO_W-1:0] shadow;
  logic [PRIO_W-1:0] entry;
  logic [1:0] err_code_d;
  logic verify, error_d, accept, last, expired, mismatch;

  assign entry = shadow[idx*PRIO_W +: PRIO_W];
  assign valid = state == S_WRITE || state == S_RD_REQ;
  assign wr_rd = state == S_WRITE;
  assign peripheral_index = idx;
  assign wr_priorities = entry;
  assign busy = valid || state == S_RD_CHK;
  assign done = state == S_FINISH;
  assign accept = valid && ready;
  assign last = idx == IDX_W'(NUM_PERIPH - 1);
  assign mismatch = rd_priorities != entry;

  handshake_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clear(accept || !valid),
    .en(valid && !ready),
    .expired(expired)
  );

  // next state, entry index and error bookkeeping; abort and timeout override the normal flow
  always_comb begin
    state_d = state;
    idx_d = idx;
    error_d = error;
    err_code_d = err_code;
    err_index_d = err_index;
    case (state)
      S_IDLE: if (start) begin
        state_d = S_WRITE;
        idx_d = '0;
        error_d = 1'b0;
        err_code_d = ERR_NONE;
        err_index_d = '0;
      end
      S_WRITE: if (accept) begin
        idx_d = last ? '0 : idx + 1'b1;
        state_d = !last ? S_WRITE : verify ? S_RD_REQ : S_FINISH;
      end
      S_RD_REQ: state_d = accept ? S_RD_CHK : S_RD_REQ;
      S_RD_CHK: begin
        state_d = mismatch ? S_FAIL : last ? S_FINISH : S_RD_REQ;
        idx_d = (mismatch || last) ? idx : idx + 1'b1;
        error_d = error || mismatch;
        err_code_d = mismatch ? ERR_MISMATCH : err_code;
        err_index_d = mismatch ? idx : err_index;
      end
      default: state_d = S_IDLE;
    endcase
    if (busy && (abort || expired)) begin
      state_d = S_FAIL;
      idx_d = idx;
      error_d = 1'b1;
      err_code_d = abort ? ERR_ABORT : ERR_TIMEOUT;
      err_index_d = idx;
    end
  end

  // state register, sticky error status and the table/verify capture taken on start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx <= '0;
      shadow <= '0;
      verify <= 1'b0;
      error <= 1'b0;
      err_code <= ERR_NONE;
      err_index <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      error <= error_d;
      err_code <= err_code_d;
      err_index <= err_index_d;
      if (state == S_IDLE && start) begin
        shadow <= prio_table;
        verify <= verify_en;
      end
    end
  end
endmodule
